measurement_encoder: RTL and testbench

- Forward-projection engine for the compressive-sensing datapath; the encoding counterpart of the column-contribution search.
- Accepts a 4-element sparse vector x and produces the 3-element measurement y = A·x, using the same fixed 3x4 sensing matrix A in IEEE-754 single precision.
- Its `buff_y` output is packed exactly as the column search expects, so it drives that block directly and feeds the reconstruction test loop.
- Uses one shared `floating_multiplication` and one shared `floating_adder` instance, sequenced by an FSM.

---
 rtl/measurement_encoder.sv | 347 ++++++++++++++++++++++++++++++++++
 tb/tb_measurement_encoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/measurement_encoder.sv
// measurement_encoder: y = A*x for a fixed 3x4 float32 sensing matrix, one shared FP multiplier and adder.
// Optional macro MEAS_ZERO_SKIP_EN: terms whose x_j has a zero exponent field are skipped.

module fp_delay #(
   parameter int unsigned W   = 32,
   parameter int unsigned LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_pipe [LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(LAT); i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= i_d;
         for (int i = 1; i < int'(LAT); i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_q = r_pipe[LAT-1];
endmodule

// Float32 multiply, round-to-nearest-even; denormal inputs and underflowing results flush to signed zero.
module floating_multiplication #(
   parameter int unsigned LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_p
);
   logic              w_sign, w_nan, w_inf, w_zero, w_grd, w_stk;
   logic [47:0]       w_prod;
   logic [23:0]       w_sig;
   logic [24:0]       w_rnd;
   logic [22:0]       w_frac;
   logic signed [9:0] w_exp;
   logic [31:0]       w_res;

   always_comb begin
      w_sign = i_a[31] ^ i_b[31];
      w_nan  = ((&i_a[30:23]) && (|i_a[22:0])) || ((&i_b[30:23]) && (|i_b[22:0]));
      w_inf  = (&i_a[30:23]) || (&i_b[30:23]);
      w_zero = (i_a[30:23] == 8'd0) || (i_b[30:23] == 8'd0);
      w_prod = {1'b1, i_a[22:0]} * {1'b1, i_b[22:0]};
      w_exp  = $signed({2'b00, i_a[30:23]}) + $signed({2'b00, i_b[30:23]}) - 10'sd127;
      w_sig  = w_prod[46:23];
      w_grd  = w_prod[22];
      w_stk  = |w_prod[21:0];
      if (w_prod[47]) begin
         w_sig = w_prod[47:24];
         w_grd = w_prod[23];
         w_stk = |w_prod[22:0];
         w_exp = w_exp + 10'sd1;
      end
      w_rnd  = {1'b0, w_sig} + {24'd0, w_grd & (w_stk | w_sig[0])};
      w_frac = w_rnd[22:0];
      if (w_rnd[24]) begin
         w_frac = w_rnd[23:1];
         w_exp  = w_exp + 10'sd1;
      end
      if (w_nan || (w_inf && w_zero)) w_res = 32'h7fc00000;
      else if (w_inf)                 w_res = {w_sign, 8'hff, 23'd0};
      else if (w_zero)                w_res = {w_sign, 31'd0};
      else if (w_exp >= 10'sd255)     w_res = {w_sign, 8'hff, 23'd0};
      else if (w_exp <= 10'sd0)       w_res = {w_sign, 31'd0};
      else                            w_res = {w_sign, w_exp[7:0], w_frac};
   end

   fp_delay #(.W(32), .LAT(LAT)) u_dly (.clk(clk), .rst_n(rst_n), .i_d(w_res), .o_q(o_p));
endmodule

// Float32 add, round-to-nearest-even with guard/round/sticky; same flush-to-zero policy as the multiplier.
module floating_adder #(
   parameter int unsigned LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_s
);
   logic              w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b, w_cancel;
   logic [31:0]       w_big, w_sml, w_res;
   logic [7:0]        w_d;
   logic [26:0]       w_mb, w_ms, w_msh, w_diff, w_norm;
   logic [27:0]       w_sum;
   logic [4:0]        w_lz;
   logic [24:0]       w_rnd;
   logic [22:0]       w_frac;
   logic signed [9:0] w_exp;

   function automatic logic [4:0] f_lzc(input logic [26:0] v);
      logic [4:0] n;
      n = 5'd27;
      for (int i = 0; i < 27; i++) if (v[i]) n = 5'(26 - i);
      return n;
   endfunction

   always_comb begin
      w_nan_a  = (&i_a[30:23]) && (|i_a[22:0]);
      w_nan_b  = (&i_b[30:23]) && (|i_b[22:0]);
      w_inf_a  = (&i_a[30:23]) && !(|i_a[22:0]);
      w_inf_b  = (&i_b[30:23]) && !(|i_b[22:0]);
      w_zero_a = (i_a[30:23] == 8'd0);
      w_zero_b = (i_b[30:23] == 8'd0);
      w_big    = i_a;
      w_sml    = i_b;
      if (i_b[30:0] > i_a[30:0]) begin
         w_big = i_b;
         w_sml = i_a;
      end
      w_d  = w_big[30:23] - w_sml[30:23];
      w_mb = {1'b1, w_big[22:0], 3'b000};
      w_ms = {1'b1, w_sml[22:0], 3'b000};
      // bits shifted out of the smaller operand collapse into the sticky LSB
      if (w_d > 8'd26) w_msh = 27'd1;
      else             w_msh = (w_ms >> w_d) | {26'd0, |(w_ms & ((27'd1 << w_d) - 27'd1))};
      w_exp    = $signed({2'b00, w_big[30:23]});
      w_cancel = 1'b0;
      w_sum    = '0;
      w_diff   = '0;
      w_lz     = '0;
      if (w_big[31] == w_sml[31]) begin
         w_sum  = {1'b0, w_mb} + {1'b0, w_msh};
         w_norm = w_sum[26:0];
         if (w_sum[27]) begin
            w_norm = {w_sum[27:2], |w_sum[1:0]};
            w_exp  = w_exp + 10'sd1;
         end
      end else begin
         w_diff   = w_mb - w_msh;
         w_cancel = (w_diff == 27'd0);
         w_lz     = f_lzc(w_diff);
         w_norm   = w_diff << w_lz;
         w_exp    = w_exp - $signed({5'd0, w_lz});
      end
      w_rnd  = {1'b0, w_norm[26:3]} + {24'd0, w_norm[2] & ((|w_norm[1:0]) | w_norm[3])};
      w_frac = w_rnd[22:0];
      if (w_rnd[24]) begin
         w_frac = w_rnd[23:1];
         w_exp  = w_exp + 10'sd1;
      end
      if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (i_a[31] != i_b[31]))) w_res = 32'h7fc00000;
      else if (w_inf_a)                w_res = i_a;
      else if (w_inf_b)                w_res = i_b;
      else if (w_zero_a && w_zero_b)   w_res = {i_a[31] & i_b[31], 31'd0};
      else if (w_zero_a)               w_res = i_b;
      else if (w_zero_b)               w_res = i_a;
      else if (w_cancel)               w_res = 32'd0;
      else if (w_exp >= 10'sd255)      w_res = {w_big[31], 8'hff, 23'd0};
      else if (w_exp <= 10'sd0)        w_res = {w_big[31], 31'd0};
      else                             w_res = {w_big[31], w_exp[7:0], w_frac};
   end

   fp_delay #(.W(32), .LAT(LAT)) u_dly (.clk(clk), .rst_n(rst_n), .i_d(w_res), .o_q(o_s));
endmodule

module measurement_encoder #(
   parameter int unsigned MUL_LAT = 1,
   parameter int unsigned ADD_LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] buff_x,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [95:0]  buff_y
);
   localparam int unsigned MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
   localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1) + 1;
`ifdef MEAS_ZERO_SKIP_EN
   localparam logic ZERO_SKIP = 1'b1;
`else
   localparam logic ZERO_SKIP = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_ADD, S_NEXT, S_DONE} state_t;

   state_t           r_state;
   logic [127:0]     r_x;
   logic [1:0]       r_row, r_col;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_acc, r_prod;
   logic             r_first;

   logic [31:0] w_xj, w_mul_a, w_mul_p, w_add_s, w_acc_new;
   logic [1:0]  w_ncol;
   logic        w_last_col, w_adv;
   state_t      w_nstate;
   logic [95:0] w_y_new;

   function automatic logic [31:0] f_amat(input logic [1:0] row, input logic [1:0] col);
      logic [31:0] a;
      case ({row, col})
         4'h0: a = 32'h3f000000;
         4'h1: a = 32'hbfc00000;
         4'h2: a = 32'hbf400000;
         4'h3: a = 32'hbf600000;
         4'h4: a = 32'h3f400000;
         4'h5: a = 32'h3f000000;
         4'h6: a = 32'hbf400000;
         4'h7: a = 32'hbfa00000;
         4'h8: a = 32'h3f400000;
         4'h9: a = 32'hbe000000;
         4'ha: a = 32'h3fb00000;
         4'hb: a = 32'h3e800000;
         default: a = 32'h0;
      endcase
      return a;
   endfunction

   function automatic logic [31:0] f_xsel(input logic [127:0] x, input logic [1:0] col);
      logic [31:0] v;
      case (col)
         2'd0:    v = x[127:96];
         2'd1:    v = x[95:64];
         2'd2:    v = x[63:32];
         default: v = x[31:0];
      endcase
      return v;
   endfunction

   function automatic logic f_skip(input logic [31:0] x);
      return ZERO_SKIP && (x[30:23] == 8'd0);
   endfunction

   floating_multiplication #(.LAT(MUL_LAT)) u_mul (
      .clk(clk), .rst_n(rst_n), .i_a(w_mul_a), .i_b(w_xj), .o_p(w_mul_p));

   floating_adder #(.LAT(ADD_LAT)) u_add (
      .clk(clk), .rst_n(rst_n), .i_a(r_acc), .i_b(r_prod), .o_s(w_add_s));

   // Term-completion decision: where the sequencer goes once the current term is finished.
   always_comb begin
      w_xj       = f_xsel(r_x, r_col);
      w_mul_a    = f_amat(r_row, r_col);
      w_ncol     = r_col + 2'd1;
      w_last_col = (r_col == 2'd3);
      w_nstate   = S_MUL;
      if (w_last_col && (r_row == 2'd2))  w_nstate = S_DONE;
      else if (f_skip(f_xsel(r_x, w_ncol))) w_nstate = S_NEXT;
      w_acc_new = r_acc;
      w_adv     = 1'b0;
      case (r_state)
         S_MUL: begin
            w_acc_new = w_mul_p;
            w_adv     = (r_cnt == CNT_W'(MUL_LAT)) && r_first;
         end
         S_ADD: begin
            w_acc_new = w_add_s;
            w_adv     = (r_cnt == CNT_W'(ADD_LAT));
         end
         S_NEXT:  w_adv = 1'b1;
         default: w_adv = 1'b0;
      endcase
      case (r_row)
         2'd0:    w_y_new = {w_acc_new, buff_y[63:0]};
         2'd1:    w_y_new = {buff_y[95:64], w_acc_new, buff_y[31:0]};
         default: w_y_new = {buff_y[95:32], w_acc_new};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_x       <= '0;
         r_row     <= '0;
         r_col     <= '0;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_prod    <= '0;
         r_first   <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         buff_y    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  r_x      <= buff_x;
                  r_row    <= 2'd0;
                  r_col    <= 2'd0;
                  r_cnt    <= '0;
                  r_acc    <= '0;
                  r_first  <= 1'b1;
                  r_state  <= f_skip(buff_x[127:96]) ? S_NEXT : S_MUL;
               end
            end
            S_MUL: begin
               if (r_cnt == CNT_W'(MUL_LAT)) begin
                  r_cnt <= '0;
                  if (r_first) begin
                     r_acc   <= w_mul_p;
                     r_first <= 1'b0;
                  end else begin
                     r_prod  <= w_mul_p;
                     r_state <= S_ADD;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_ADD: begin
               if (r_cnt == CNT_W'(ADD_LAT)) begin
                  r_cnt <= '0;
                  r_acc <= w_add_s;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_NEXT: r_cnt <= '0;
            S_DONE: begin
               // first DONE cycle only raises out_valid, giving the +1 of the fixed latency
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_adv) begin
            r_col   <= w_ncol;
            r_state <= w_nstate;
            if (w_last_col) begin
               buff_y  <= w_y_new;
               r_row   <= r_row + 2'd1;
               r_acc   <= '0;
               r_first <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_measurement_encoder.sv
// Self-checking bench for measurement_encoder: directed handshake/reset cases plus random vectors
// checked against a real-arithmetic model of y = A*x (values chosen so every float op is exact).

module tb_measurement_encoder;
   localparam int unsigned MUL_LAT = 1;
   localparam int unsigned ADD_LAT = 1;
`ifdef MEAS_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [127:0] buff_x;
   logic [95:0]  buff_y;
   int           n_total, n_bad;
   logic [31:0]  a_hex [3][4];

   measurement_encoder #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .buff_x(buff_x),
      .out_valid(out_valid), .out_ready(out_ready), .buff_y(buff_y));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // exact values only: repack a double into float32 fields
   function automatic logic [31:0] to_f32(input real r);
      logic [63:0] b;
      b = $realtobits(r);
      if (b[62:52] == 11'd0) return {b[63], 31'd0};
      return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
   endfunction

   function automatic real to_real(input logic [31:0] f);
      logic [63:0] b;
      if (f[30:23] == 8'd0) b = {f[31], 63'd0};
      else                  b = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(b);
   endfunction

   function automatic logic [95:0] model_y(input real xv[4]);
      logic [95:0] y;
      y = '0;
      for (int i = 0; i < 3; i++) begin
         real acc;
         bit  loaded;
         acc    = 0.0;
         loaded = 1'b0;
         for (int j = 0; j < 4; j++) begin
            if (!(SKIP && xv[j] == 0.0)) begin
               if (loaded) acc = acc + to_real(a_hex[i][j]) * xv[j];
               else        acc = to_real(a_hex[i][j]) * xv[j];
               loaded = 1'b1;
            end
         end
         y[95-32*i -: 32] = to_f32(acc);
      end
      return y;
   endfunction

   function automatic int model_lat(input real xv[4]);
      int lat;
      lat = 1;
      for (int i = 0; i < 3; i++) begin
         bit loaded;
         loaded = 1'b0;
         for (int j = 0; j < 4; j++) begin
            if (SKIP && xv[j] == 0.0) lat += 1;
            else if (!loaded)         lat += int'(MUL_LAT) + 1;
            else                      lat += int'(MUL_LAT) + int'(ADD_LAT) + 2;
            if (!(SKIP && xv[j] == 0.0)) loaded = 1'b1;
         end
      end
      return lat;
   endfunction

   task automatic run_vec(input real xv[4], input logic [95:0] exp_y, input int hold,
                          input bit pre_rdy, input string tag);
      int cnt;
      in_valid = 1'b1;
      buff_x   = {to_f32(xv[0]), to_f32(xv[1]), to_f32(xv[2]), to_f32(xv[3])};
      cnt = 0;
      while (!in_ready && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check({tag, " accept"}, 96'(in_ready), 96'd1);
      @(negedge clk);
      in_valid = 1'b0;
      buff_x   = {$urandom, $urandom, $urandom, $urandom};
      if (pre_rdy) out_ready = 1'b1;
      cnt = 0;
      while (!out_valid && cnt < 300) begin
         @(negedge clk);
         cnt++;
      end
      check({tag, " latency"}, 96'(cnt), 96'(model_lat(xv)));
      check({tag, " y"}, buff_y, exp_y);
      for (int k = 0; k < hold; k++) begin
         in_valid = 1'($urandom);
         buff_x   = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         check({tag, " hold y"}, buff_y, exp_y);
         check({tag, " hold flags"}, 96'({in_ready, out_valid}), 96'(2'b01));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " release"}, 96'({in_ready, out_valid}), 96'(2'b10));
   endtask

   initial begin
      real v [4];
      int  cnt, hold;
      n_total = 0;
      n_bad   = 0;
      a_hex = '{'{32'h3f000000, 32'hbfc00000, 32'hbf400000, 32'hbf600000},
                '{32'h3f400000, 32'h3f000000, 32'hbf400000, 32'hbfa00000},
                '{32'h3f400000, 32'hbe000000, 32'h3fb00000, 32'h3e800000}};

      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      buff_x    = {$urandom, $urandom, $urandom, $urandom};
      repeat (3) @(negedge clk);
      check("reset in_ready", 96'(in_ready), 96'd0);
      check("reset out_valid", 96'(out_valid), 96'd0);
      check("reset buff_y", buff_y, 96'd0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      check("in_ready after release", 96'(in_ready), 96'd1);

      v = '{1.0, 0.0, 0.0, 0.0};
      run_vec(v, 96'h3f000000_3f400000_3f400000, 0, 1'b0, "x1000");
      v = '{1.0, 1.0, 1.0, 1.0};
      run_vec(v, 96'hc0280000_bf400000_40100000, 0, 1'b1, "x1111");
      v = '{2.5, -1.0, 0.25, 4.0};
      run_vec(v, model_y(v), 20, 1'b0, "backpressure");
      v = '{-3.0, 0.5, 7.0, -0.25};
      run_vec(v, model_y(v), 0, 1'b0, "after backpressure");

      // reset in the middle of a computation
      in_valid = 1'b1;
      buff_x   = {32'h40000000, 32'h40400000, 32'h3f800000, 32'hbf800000};
      cnt = 0;
      while (!in_ready && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset out_valid", 96'(out_valid), 96'd0);
      check("midreset in_ready", 96'(in_ready), 96'd0);
      check("midreset buff_y", buff_y, 96'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("midreset stale out_valid cycles", 96'(cnt), 96'd0);
      v = '{1.0, 0.0, 0.0, 0.0};
      run_vec(v, 96'h3f000000_3f400000_3f400000, 0, 1'b0, "x1000 after reset");

      v = '{0.0, 0.0, 0.0, 0.0};
      run_vec(v, 96'h0, 0, 1'b0, "all zero");
      v = '{0.0, 2.0, 0.0, 0.0};
      run_vec(v, 96'hc0400000_3f800000_be800000, 0, 1'b0, "x0200");

      for (int t = 0; t < 24; t++) begin
         for (int j = 0; j < 4; j++) begin
            if ($urandom_range(3) == 0) v[j] = 0.0;
            else v[j] = real'(int'($urandom_range(2048)) - 1024) / 4.0;
         end
         hold = int'($urandom_range(3));
         run_vec(v, model_y(v), hold, (hold == 0) ? 1'($urandom) : 1'b0, $sformatf("rand%0d", t));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
